// File: rtl/magic_ctrl_pkg.sv
// Shared types and default addresses for the magic-button controller.
package common;

  typedef enum logic [2:0] {
    MAGIC_IDLE,
    MAGIC_ARMED,
    MAGIC_MAPPED,
    MAGIC_UNMAP,
    MAGIC_REMAP_WAIT,
    MAGIC_UNMAP_REMAP
  } magic_state_t;

  localparam logic [15:0] MAGIC_ENTRY_ADDR   = 16'h0066;
  localparam logic [15:0] MAGIC_EXIT_ADDR    = 16'hF000;
  localparam logic [15:0] MAGIC_REENTRY_ADDR = 16'hF008;
  localparam logic [7:0]  MAGIC_CFG_PORT     = 8'hFF;

endpackage

// File: rtl/cpu_bus.sv
// Z80 CPU bus as seen by the mappers; qualifiers are active-high.
interface cpu_bus;
  logic        memreq;
  logic        ioreq;
  logic        m1;
  logic        rd;
  logic        wr;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;

  modport ctrl (input memreq, ioreq, m1, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/magic_cfg_regs.sv
// Config register bank with registered readback; index 15 reads the trigger cause.
module magic_cfg_regs #(
  parameter int NSRC     = 2,
  parameter int CFG_REGS = 8,
  parameter int CFG_W    = 2,
  parameter logic [CFG_REGS*CFG_W-1:0] CFG_RESET = '0
) (
  input  logic                      clk28,
  input  logic                      rst,
  input  logic                      wr_stb,
  input  logic                      rd_stb,
  input  logic [3:0]                idx,
  input  logic [7:0]                wdata,
  input  logic [NSRC-1:0]           cause,
  output logic [CFG_REGS*CFG_W-1:0] cfg,
  output logic [7:0]                d_out,
  output logic                      d_out_active
);

  logic [7:0] d_out_next;
  logic       d_out_active_next;

  genvar gi;
  generate
    for (gi = 0; gi < CFG_REGS; gi++) begin : g_reg
      logic [CFG_W-1:0] val_reg;

      always_ff @(posedge clk28) begin
        if (rst) begin
          val_reg <= CFG_RESET[gi*CFG_W +: CFG_W];
        end else if (wr_stb && idx == 4'(gi)) begin
          val_reg <= wdata[CFG_W-1:0];
        end
      end

      assign cfg[gi*CFG_W +: CFG_W] = val_reg;
    end
  endgenerate

  // Out-of-range indices other than 15 read back as zero.
  always_comb begin
    d_out_next        = 8'h00;
    d_out_active_next = 1'b0;
    if (rd_stb) begin
      d_out_active_next = 1'b1;
      if (idx == 4'hF) begin
        d_out_next = 8'(cause);
      end else begin
        for (int k = 0; k < CFG_REGS; k++) begin
          if (idx == 4'(k)) d_out_next = 8'(cfg[k*CFG_W +: CFG_W]);
        end
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      d_out        <= 8'h00;
      d_out_active <= 1'b0;
    end else begin
      d_out        <= d_out_next;
      d_out_active <= d_out_active_next;
    end
  end

endmodule

// File: rtl/magic_ctrl.sv
// NMI arbitration at frame edges plus map/unmap sequencing of the magic ROM overlay.
module magic_ctrl
  import common::*;
#(
  parameter int          NSRC         = 2,
  parameter int          CFG_REGS     = 8,
  parameter int          CFG_W        = 2,
  parameter logic [CFG_REGS*CFG_W-1:0] CFG_RESET = '0,
  parameter logic [7:0]  CFG_PORT     = MAGIC_CFG_PORT,
  parameter logic [15:0] ENTRY_ADDR   = MAGIC_ENTRY_ADDR,
  parameter logic [15:0] EXIT_ADDR    = MAGIC_EXIT_ADDR,
  parameter logic [15:0] REENTRY_ADDR = MAGIC_REENTRY_ADDR,
  parameter int          NMI_TIMEOUT  = 4
) (
  input  logic                      clk28,
  input  logic                      rst,
  cpu_bus.ctrl                      bus,
  input  logic                      n_int,
  input  logic                      n_int_next,
  input  logic [NSRC-1:0]           nmi_src,
  output logic                      n_nmi,
  output logic                      magic_mode,
  output logic                      magic_map,
  output logic                      magic_active_next,
  output logic [NSRC-1:0]           cause,
  output logic [CFG_REGS*CFG_W-1:0] cfg,
  output logic [7:0]                d_out,
  output logic                      d_out_active
);

  localparam int CNT_W = $clog2(NMI_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(NMI_TIMEOUT);

  generate
    if (EXIT_ADDR == REENTRY_ADDR) begin : g_chk_addr
      $error("magic_ctrl: EXIT_ADDR and REENTRY_ADDR must differ");
    end
    if (CFG_REGS < 1 || CFG_REGS > 15 || CFG_W < 1 || CFG_W > 8) begin : g_chk_cfg
      $error("magic_ctrl: CFG_REGS must be 1..15 and CFG_W 1..8");
    end
  endgenerate

  magic_state_t     state_reg, state_next;
  logic             n_nmi_reg, n_nmi_next;
  logic             mode_reg, mode_next;
  logic             map_reg, map_next;
  logic [NSRC-1:0]  cause_reg, cause_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             fe;
  logic             port_hit;

  assign fe                = n_int & ~n_int_next;
  assign magic_active_next = |nmi_src;

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_reg <= MAGIC_IDLE;
      n_nmi_reg <= 1'b1;
      mode_reg  <= 1'b0;
      map_reg   <= 1'b0;
      cause_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      n_nmi_reg <= n_nmi_next;
      mode_reg  <= mode_next;
      map_reg   <= map_next;
      cause_reg <= cause_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Saturating frame count while waiting for the CPU to take the NMI.
  assign cnt_inc = (fe && cnt_reg != TMO) ? cnt_reg + CNT_W'(1) : cnt_reg;

  always_comb begin
    state_next = state_reg;
    n_nmi_next = n_nmi_reg;
    mode_next  = mode_reg;
    map_next   = map_reg;
    cause_next = cause_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MAGIC_IDLE: begin
        if (fe && |nmi_src) begin
          cause_next = nmi_src;
          n_nmi_next = 1'b0;
          mode_next  = 1'b1;
          cnt_next   = '0;
          state_next = MAGIC_ARMED;
        end
      end
      MAGIC_ARMED: begin
        if (bus.m1 && bus.memreq && bus.a_reg == ENTRY_ADDR) begin
          n_nmi_next = 1'b1;
          map_next   = 1'b1;
          state_next = MAGIC_MAPPED;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == TMO) begin
            n_nmi_next = 1'b1;
            mode_next  = 1'b0;
            state_next = MAGIC_IDLE;
          end
        end
      end
      MAGIC_MAPPED: begin
        if (bus.memreq && bus.rd) begin
          if (bus.a_reg == EXIT_ADDR) begin
            mode_next  = 1'b0;
            state_next = MAGIC_UNMAP;
          end else if (bus.a_reg == REENTRY_ADDR) begin
            state_next = MAGIC_UNMAP_REMAP;
          end
        end
      end
      MAGIC_UNMAP: begin
        if (!bus.memreq) begin
          map_next   = 1'b0;
          state_next = MAGIC_IDLE;
        end
      end
      MAGIC_UNMAP_REMAP: begin
        if (!bus.memreq) begin
          map_next   = 1'b0;
          state_next = MAGIC_REMAP_WAIT;
        end
      end
      MAGIC_REMAP_WAIT: begin
        if (bus.m1 && bus.memreq) begin
          map_next   = 1'b1;
          state_next = MAGIC_MAPPED;
        end
      end
      default: state_next = MAGIC_IDLE;
    endcase
  end

  assign n_nmi      = n_nmi_reg;
  assign magic_mode = mode_reg;
  assign magic_map  = map_reg;
  assign cause      = cause_reg;

  assign port_hit = map_reg && bus.ioreq && bus.a_reg[7:0] == CFG_PORT;

  magic_cfg_regs #(
    .NSRC     (NSRC),
    .CFG_REGS (CFG_REGS),
    .CFG_W    (CFG_W),
    .CFG_RESET(CFG_RESET)
  ) u_cfg (
    .clk28       (clk28),
    .rst         (rst),
    .wr_stb      (port_hit && bus.wr),
    .rd_stb      (port_hit && bus.rd),
    .idx         (bus.a_reg[15:12]),
    .wdata       (bus.d_reg),
    .cause       (cause_reg),
    .cfg         (cfg),
    .d_out       (d_out),
    .d_out_active(d_out_active)
  );

endmodule

// File: tb/tb_magic_ctrl.sv
// Directed bench for magic_ctrl: entry, config, exit, reentry, timeout and reset.
module tb_magic_ctrl;

  localparam logic [15:0] RST_IMG = 16'h1B4E;

  logic        clk28 = 1'b0;
  logic        rst;
  logic        n_int, n_int_next;
  logic [1:0]  nmi_src;
  logic        n_nmi, magic_mode, magic_map, magic_active_next;
  logic [1:0]  cause;
  logic [15:0] cfg;
  logic [7:0]  d_out;
  logic        d_out_active;
  int          n_checks = 0;
  int          n_fail   = 0;

  cpu_bus bus_if ();

  magic_ctrl #(
    .NSRC(2), .CFG_REGS(8), .CFG_W(2), .CFG_RESET(RST_IMG), .NMI_TIMEOUT(4)
  ) dut (
    .clk28(clk28), .rst(rst), .bus(bus_if), .n_int(n_int), .n_int_next(n_int_next),
    .nmi_src(nmi_src), .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
    .magic_active_next(magic_active_next), .cause(cause), .cfg(cfg),
    .d_out(d_out), .d_out_active(d_out_active)
  );

  always #5 clk28 = ~clk28;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_set(input logic mreq, input logic ioq, input logic m1, input logic rd,
                         input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus_if.memreq = mreq; bus_if.ioreq = ioq; bus_if.m1 = m1;
    bus_if.rd = rd; bus_if.wr = wr; bus_if.a_reg = a; bus_if.d_reg = d;
  endtask

  task automatic bus_idle();
    bus_set(0, 0, 0, 0, 0, 16'h0000, 8'h00);
  endtask

  task automatic fe_pulse();
    n_int_next = 1'b0;
    tick();
    n_int_next = 1'b1;
  endtask

  task automatic test_reset();
    $display("test_reset: rst held");
    n_checks++; if (n_nmi !== 1'b1) begin n_fail++; $display("FAIL rst_n_nmi got %b want 1", n_nmi); end
    n_checks++; if (magic_mode !== 1'b0) begin n_fail++; $display("FAIL rst_mode got %b want 0", magic_mode); end
    n_checks++; if (magic_map !== 1'b0) begin n_fail++; $display("FAIL rst_map got %b want 0", magic_map); end
    n_checks++; if (cause !== 2'b00) begin n_fail++; $display("FAIL rst_cause got %b want 00", cause); end
    n_checks++; if (cfg !== RST_IMG) begin n_fail++; $display("FAIL rst_cfg got %h want %h", cfg, RST_IMG); end
    n_checks++; if (d_out !== 8'h00 || d_out_active !== 1'b0) begin n_fail++; $display("FAIL rst_dout got %h/%b want 00/0", d_out, d_out_active); end
    rst = 1'b0;
    nmi_src = 2'b10; #1;
    n_checks++; if (magic_active_next !== 1'b1) begin n_fail++; $display("FAIL active_next got %b want 1", magic_active_next); end
    nmi_src = 2'b00; #1;
    n_checks++; if (magic_active_next !== 1'b0) begin n_fail++; $display("FAIL active_next_0 got %b want 0", magic_active_next); end
    tick();
  endtask

  task automatic test_entry();
    $display("test_entry: src=01, frame edge, M1 at 0066");
    nmi_src = 2'b01;
    tick();
    n_checks++; if (n_nmi !== 1'b1) begin n_fail++; $display("FAIL no_fe_trigger got %b want 1", n_nmi); end
    fe_pulse();
    nmi_src = 2'b00;
    n_checks++; if (n_nmi !== 1'b0) begin n_fail++; $display("FAIL entry_n_nmi got %b want 0", n_nmi); end
    n_checks++; if (cause !== 2'b01) begin n_fail++; $display("FAIL entry_cause got %b want 01", cause); end
    n_checks++; if (magic_mode !== 1'b1 || magic_map !== 1'b0) begin n_fail++; $display("FAIL entry_mode_map got %b%b want 10", magic_mode, magic_map); end
    bus_set(1, 0, 1, 1, 0, 16'h0066, 8'h00);
    tick();
    n_checks++; if (n_nmi !== 1'b1 || magic_map !== 1'b1) begin n_fail++; $display("FAIL entry_fetch got nmi=%b map=%b want 1/1", n_nmi, magic_map); end
    bus_idle();
    tick();
  endtask

  task automatic test_config();
    $display("test_config: mapped port writes and reads");
    bus_set(0, 1, 0, 0, 1, 16'h30FF, 8'h03); tick(); bus_idle();
    n_checks++; if (cfg !== 16'h1BCE) begin n_fail++; $display("FAIL cfg_wr3 got %h want 1bce", cfg); end
    bus_set(0, 1, 0, 1, 0, 16'h30FF, 8'h00); tick();
    n_checks++; if (d_out !== 8'h03 || d_out_active !== 1'b1) begin n_fail++; $display("FAIL cfg_rd3 got %h/%b want 03/1", d_out, d_out_active); end
    tick();
    n_checks++; if (d_out !== 8'h03 || d_out_active !== 1'b1) begin n_fail++; $display("FAIL cfg_rd3_hold got %h/%b want 03/1", d_out, d_out_active); end
    bus_idle(); tick();
    n_checks++; if (d_out !== 8'h00 || d_out_active !== 1'b0) begin n_fail++; $display("FAIL cfg_rd_drop got %h/%b want 00/0", d_out, d_out_active); end
    bus_set(0, 1, 0, 1, 0, 16'hF0FF, 8'h00); tick();
    n_checks++; if (d_out !== 8'h01 || d_out_active !== 1'b1) begin n_fail++; $display("FAIL cfg_rd_cause got %h/%b want 01/1", d_out, d_out_active); end
    bus_set(0, 1, 0, 1, 0, 16'h90FF, 8'h00); tick();
    n_checks++; if (d_out !== 8'h00 || d_out_active !== 1'b1) begin n_fail++; $display("FAIL cfg_rd_oor got %h/%b want 00/1", d_out, d_out_active); end
    bus_set(0, 1, 0, 1, 0, 16'h00FF, 8'h00); tick();
    n_checks++; if (d_out !== 8'h02) begin n_fail++; $display("FAIL cfg_rd0 got %h want 02", d_out); end
    bus_set(0, 1, 0, 0, 1, 16'h90FF, 8'h03); tick();
    n_checks++; if (cfg !== 16'h1BCE) begin n_fail++; $display("FAIL cfg_wr_oor got %h want 1bce", cfg); end
    bus_set(0, 1, 0, 0, 1, 16'h10FF, 8'hFE); tick();
    n_checks++; if (cfg !== 16'h1BCA) begin n_fail++; $display("FAIL cfg_wr1_trunc got %h want 1bca", cfg); end
    bus_set(0, 1, 0, 0, 1, 16'h20FE, 8'h03); tick();
    n_checks++; if (cfg !== 16'h1BCA) begin n_fail++; $display("FAIL cfg_wrong_port got %h want 1bca", cfg); end
    bus_idle(); tick();
  endtask

  task automatic test_exit();
    $display("test_exit: read F000, then memreq drop");
    bus_set(1, 0, 0, 1, 0, 16'hF000, 8'h00); tick();
    n_checks++; if (magic_mode !== 1'b0 || magic_map !== 1'b1) begin n_fail++; $display("FAIL exit_rd got mode=%b map=%b want 0/1", magic_mode, magic_map); end
    tick();
    n_checks++; if (magic_map !== 1'b1) begin n_fail++; $display("FAIL exit_hold_map got %b want 1", magic_map); end
    bus_idle(); tick();
    n_checks++; if (magic_map !== 1'b0) begin n_fail++; $display("FAIL exit_unmap got %b want 0", magic_map); end
    bus_set(0, 1, 0, 0, 1, 16'h30FF, 8'h00); tick();
    n_checks++; if (cfg !== 16'h1BCA) begin n_fail++; $display("FAIL unmapped_wr got %h want 1bca", cfg); end
    bus_set(0, 1, 0, 1, 0, 16'h30FF, 8'h00); tick();
    n_checks++; if (d_out_active !== 1'b0) begin n_fail++; $display("FAIL unmapped_rd got %b want 0", d_out_active); end
    bus_idle(); tick();
  endtask

  task automatic test_reentry();
    $display("test_reentry: src=10, F008, M1 at 1234");
    nmi_src = 2'b10; fe_pulse(); nmi_src = 2'b00;
    n_checks++; if (n_nmi !== 1'b0 || cause !== 2'b10 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL re_trigger got nmi=%b cause=%b mode=%b want 0/10/1", n_nmi, cause, magic_mode); end
    bus_set(1, 0, 1, 1, 0, 16'h0066, 8'h00); tick();
    n_checks++; if (magic_map !== 1'b1) begin n_fail++; $display("FAIL re_map got %b want 1", magic_map); end
    bus_idle(); tick();
    bus_set(1, 0, 0, 1, 0, 16'hF008, 8'h00); tick();
    n_checks++; if (magic_map !== 1'b1 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL re_rd got map=%b mode=%b want 1/1", magic_map, magic_mode); end
    bus_idle(); tick();
    n_checks++; if (magic_map !== 1'b0 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL re_unmap got map=%b mode=%b want 0/1", magic_map, magic_mode); end
    tick();
    n_checks++; if (magic_map !== 1'b0) begin n_fail++; $display("FAIL re_wait got %b want 0", magic_map); end
    bus_set(1, 0, 1, 1, 0, 16'h1234, 8'h00); tick();
    n_checks++; if (magic_map !== 1'b1 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL re_remap got map=%b mode=%b want 1/1", magic_map, magic_mode); end
    bus_idle(); tick();
  endtask

  task automatic test_back_to_back();
    $display("test_back_to_back: trigger on the unmap edge");
    bus_set(1, 0, 0, 1, 0, 16'hF000, 8'h00); tick();
    bus_idle(); nmi_src = 2'b01; fe_pulse();
    n_checks++; if (n_nmi !== 1'b1 || magic_map !== 1'b0 || cause !== 2'b10) begin n_fail++; $display("FAIL b2b_ignored got nmi=%b map=%b cause=%b want 1/0/10", n_nmi, magic_map, cause); end
    tick(); fe_pulse(); nmi_src = 2'b00;
    n_checks++; if (n_nmi !== 1'b0 || cause !== 2'b01 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL b2b_next got nmi=%b cause=%b mode=%b want 0/01/1", n_nmi, cause, magic_mode); end
  endtask

  task automatic test_timeout();
    $display("test_timeout: four frames without entry fetch");
    for (int i = 1; i <= 3; i++) begin
      tick(); tick(); fe_pulse(); tick();
      n_checks++; if (n_nmi !== 1'b0 || magic_mode !== 1'b1) begin n_fail++; $display("FAIL tmo_frame%0d got nmi=%b mode=%b want 0/1", i, n_nmi, magic_mode); end
    end
    tick(); fe_pulse();
    n_checks++; if (n_nmi !== 1'b1 || magic_mode !== 1'b0) begin n_fail++; $display("FAIL tmo_expire got nmi=%b mode=%b want 1/0", n_nmi, magic_mode); end
    n_checks++; if (cause !== 2'b01) begin n_fail++; $display("FAIL tmo_cause got %b want 01", cause); end
    tick();
  endtask

  task automatic test_reset_armed();
    $display("test_reset_armed: reset while n_nmi low");
    nmi_src = 2'b01; fe_pulse(); nmi_src = 2'b00;
    n_checks++; if (n_nmi !== 1'b0) begin n_fail++; $display("FAIL ra_armed got %b want 0", n_nmi); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (n_nmi !== 1'b1 || magic_mode !== 1'b0 || magic_map !== 1'b0 || cause !== 2'b00) begin n_fail++; $display("FAIL ra_outputs got nmi=%b mode=%b map=%b cause=%b want 1/0/0/00", n_nmi, magic_mode, magic_map, cause); end
    n_checks++; if (cfg !== RST_IMG) begin n_fail++; $display("FAIL ra_cfg got %h want %h", cfg, RST_IMG); end
    bus_set(1, 0, 1, 1, 0, 16'h0066, 8'h00); tick();
    n_checks++; if (magic_map !== 1'b0 || n_nmi !== 1'b1) begin n_fail++; $display("FAIL ra_idle got map=%b nmi=%b want 0/1", magic_map, n_nmi); end
    bus_idle(); tick();
  endtask

  initial begin
    rst = 1'b1; n_int = 1'b1; n_int_next = 1'b1; nmi_src = 2'b00;
    bus_idle();
    tick(); tick();
    test_reset();
    test_entry();
    test_config();
    test_exit();
    test_reentry();
    test_back_to_back();
    test_timeout();
    test_reset_armed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
